// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and step count for the EX-stage multiply/divide unit.
package muldiv_pkg;
  localparam int MULDIV_STEPS = 32;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} muldivOp_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX} muldivState_t;
  function automatic logic [31:0] absVal(input logic [31:0] v, input logic signedOp);
    return (signedOp && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring divide on magnitudes.
module muldiv_step (
  input  logic        isDiv,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] operand,
  output logic [31:0] hiNext,
  output logic [31:0] loNext
);
  logic [32:0] sum, shifted;
  logic [31:0] diff;
  logic        fits;
  always_comb begin
    sum     = {1'b0, hi} + {1'b0, lo[0] ? operand : 32'd0};
    shifted = {hi, lo[31]};
    fits    = shifted >= {1'b0, operand};
    diff    = shifted[31:0] - operand;
    hiNext  = isDiv ? (fits ? diff : shifted[31:0]) : sum[32:1];
    loNext  = isDiv ? {lo[30:0], fits} : {sum[0], lo[31:1]};
  end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic        HiWe,
  input  logic        LoWe,
  input  logic        HiLoRead,
  input  logic        Flush,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Stall,
  output logic        Done
);
  muldivState_t state;
  muldivOp_t    opIn;
  logic [4:0]   count;
  logic [31:0]  hiAcc, loAcc, operand, hiStep, loStep, hiFix, loFix;
  logic [63:0]  prod;
  logic         isDiv, negQ, negR, divZero, signedOp, divOp;
  muldiv_step uStep (
    .isDiv  (isDiv),
    .hi     (hiAcc),
    .lo     (loAcc),
    .operand(operand),
    .hiNext (hiStep),
    .loNext (loStep)
  );
  always_comb begin
    opIn     = muldivOp_t'(Op);
    signedOp = opIn == OP_MULT || opIn == OP_DIV;
    divOp    = opIn == OP_DIV || opIn == OP_DIVU;
    prod     = negQ ? -{hiAcc, loAcc} : {hiAcc, loAcc};
    // remainder follows the dividend's sign, which also restores Hi=dividend on divide-by-zero
    hiFix    = isDiv ? (negR ? -hiAcc : hiAcc) : prod[63:32];
    loFix    = isDiv ? (divZero ? 32'hFFFF_FFFF : negQ ? -loAcc : loAcc) : prod[31:0];
    Busy     = state != IDLE;
    Stall    = Busy & (Start | HiLoRead | HiWe | LoWe);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      Hi      <= '0;
      Lo      <= '0;
      Done    <= 1'b0;
      hiAcc   <= '0;
      loAcc   <= '0;
      operand <= '0;
      isDiv   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (!Busy && HiWe) Hi <= ReadData1;
      if (!Busy && LoWe) Lo <= ReadData1;
      case (state)
        IDLE: if (Start && !Flush) begin
          hiAcc   <= '0;
          loAcc   <= absVal(divOp ? ReadData1 : ReadData2, signedOp);
          operand <= absVal(divOp ? ReadData2 : ReadData1, signedOp);
          isDiv   <= divOp;
          negQ    <= signedOp & (ReadData1[31] ^ ReadData2[31]);
          negR    <= signedOp & ReadData1[31];
          divZero <= ReadData2 == '0;
          count   <= '0;
          state   <= RUN;
        end
        RUN: if (Flush) state <= IDLE;
        else begin
          hiAcc <= hiStep;
          loAcc <= loStep;
          count <= count + 5'd1;
          if (count == 5'(MULDIV_STEPS - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          if (!Flush) begin
            Hi   <= hiFix;
            Lo   <= loFix;
            Done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
